// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed hex display driver: shadows a 16-bit value and scans
// its nibbles onto a shared decoder bus with active-low anodes.
module ssd_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic        load,
   input  logic        en,
   input  logic        blank_lz,
   output logic [3:0]  digit_q,
   output logic [3:0]  anode
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

   logic [15:0]      shadow;
   logic [CNT_W-1:0] prescaler;
   logic [1:0]       index;
   logic             tick;
   logic [3:0]       upper_zero;
   logic             blanked;
   logic [3:0]       digit_nxt;
   logic [3:0]       anode_nxt;

   assign tick = (prescaler == LAST_CNT);

   // upper_zero[i] is set when nibbles i..3 are all zero; digit 0 always shows
   always_comb begin
      upper_zero    = 4'b0000;
      upper_zero[1] = (shadow[15:4] == 12'h000);
      upper_zero[2] = (shadow[15:8] == 8'h00);
      upper_zero[3] = (shadow[15:12] == 4'h0);
      blanked       = blank_lz & upper_zero[index];
      digit_nxt     = shadow[4*index +: 4];
      anode_nxt     = 4'b1111;
      if (en && !blanked) begin
         anode_nxt = ~(4'b0001 << index);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow    <= 16'h0000;
         prescaler <= '0;
         index     <= 2'd0;
         digit_q   <= 4'h0;
         anode     <= 4'b1111;
      end else begin
         if (load) begin
            shadow <= value_in;
         end
         if (en) begin
            if (tick) begin
               prescaler <= '0;
               index     <= index + 2'd1;
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end
         // outputs come from pre-edge state so digit and anode move together
         digit_q <= digit_nxt;
         anode   <= anode_nxt;
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: directed test-plan steps plus random
// traffic compared against an arithmetic reference model.
module tb_ssd_scan_ctrl;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic        load;
   logic        en;
   logic        blank_lz;
   logic [3:0]  digit_q;
   logic [3:0]  anode;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state (plain integers)
   int          m_sh;
   int          m_pre;
   int          m_idx;
   logic [3:0]  e_dq;
   logic [3:0]  e_an;

   ssd_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .value_in(value_in), .load(load), .en(en),
      .blank_lz(blank_lz), .digit_q(digit_q), .anode(anode)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sh = 0; m_pre = 0; m_idx = 0;
         e_dq = 4'h0; e_an = 4'hF;
      end else begin
         e_dq = 4'((m_sh >> (4 * m_idx)) % 16);
         if (!en || (blank_lz && m_idx != 0 && (m_sh >> (4 * m_idx)) == 0))
            e_an = 4'hF;
         else
            e_an = 4'(15 - (1 << m_idx));
         if (load) m_sh = int'(value_in);
         if (en) begin
            if (m_pre == DIV - 1) begin
               m_pre = 0;
               m_idx = (m_idx + 1) % 4;
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         check("model_dq", digit_q, e_dq);
         check("model_an", anode, e_an);
      end
   endtask

   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] dq_tab [4] = '{4'h5, 4'hC, 4'h3, 4'hA};

   initial begin
      int guard;
      logic [15:0] mask;
      reset = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0; value_in = 16'h0000;
      #12;
      check("rst_an", anode, 4'b1111);
      check("rst_dq", digit_q, 4'h0);

      // 1: mid-cycle reset, then first update after release
      @(posedge clk); #1;
      reset = 1'b0; en = 1'b1; load = 1'b1; value_in = 16'hBEEF;
      step(1);
      load = 1'b0;
      step(6);
      @(posedge clk); #3;
      reset = 1'b1; #1;
      check("midrst_an", anode, 4'b1111);
      check("midrst_dq", digit_q, 4'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      step(1);
      check("rel_an", anode, 4'b1110);
      check("rel_dq", digit_q, 4'h0);

      // 2: plain scan of A3C5, each digit held DIV clocks
      @(posedge clk); #1;
      reset = 1'b1; value_in = 16'hA3C5; load = 1'b1; en = 1'b0; blank_lz = 1'b0;
      #2 reset = 1'b0;
      step(1);
      load = 1'b0; en = 1'b1;
      for (int c = 0; c < 32; c++) begin
         step(1);
         check("scan_an", anode, an_tab[(c / DIV) % 4]);
         check("scan_dq", digit_q, dq_tab[(c / DIV) % 4]);
      end

      // 4: enable gating during index 2
      guard = 0;
      while (m_idx != 2 && guard < 20) begin step(1); guard++; end
      if (m_idx != 2) begin n_fail++; $display("FAIL wait_idx2 observed=timeout required=index 2"); end
      en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step(1);
         check("gate_an", anode, 4'b1111);
      end
      en = 1'b1;
      for (int c = 0; c < DIV; c++) begin
         step(1);
         check("resume_an", anode, 4'b1011);
         check("resume_dq", digit_q, 4'h3);
      end
      step(1);
      check("resume_next_an", anode, 4'b0111);
      check("resume_next_dq", digit_q, 4'hA);

      // 5: load coinciding with the tick out of index 0
      guard = 0;
      while (!(m_idx == 0 && m_pre == DIV - 1) && guard < 40) begin step(1); guard++; end
      if (!(m_idx == 0 && m_pre == DIV - 1)) begin
         n_fail++; $display("FAIL wait_tick observed=timeout required=tick from index 0");
      end
      load = 1'b1; value_in = 16'h1234;
      step(1);
      load = 1'b0;
      step(1);
      check("ldtick_an", anode, 4'b1101);
      check("ldtick_dq", digit_q, 4'h3);

      // 3: leading-zero blanking
      blank_lz = 1'b1; load = 1'b1; value_in = 16'h0042;
      step(1);
      load = 1'b0;
      step(1);
      for (int c = 0; c < 16; c++) begin
         step(1);
         check("lz42_hi_off", {2'b00, anode[3:2]}, 4'b0011);
      end
      load = 1'b1; value_in = 16'h0000;
      step(1);
      load = 1'b0;
      step(1);
      for (int c = 0; c < 16; c++) begin
         step(1);
         check("lz0_dq", digit_q, 4'h0);
         check("lz0_hi_off", {1'b0, anode[3:1]}, 4'b0111);
      end

      // 6: load while disabled
      blank_lz = 1'b0; en = 1'b0; load = 1'b1; value_in = 16'hFFFF;
      step(1);
      load = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step(1);
         check("dis_an", anode, 4'b1111);
      end
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         step(1);
         check("ffff_dq", digit_q, 4'hF);
      end

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         case ($urandom_range(4, 0))
            0: mask = 16'hFFFF;
            1: mask = 16'h0FFF;
            2: mask = 16'h00FF;
            3: mask = 16'h000F;
            default: mask = 16'h0000;
         endcase
         value_in = 16'($urandom) & mask;
         load     = ($urandom_range(7, 0) == 0);
         if ($urandom_range(15, 0) == 0) en = ~en;
         if ($urandom_range(31, 0) == 0) blank_lz = ~blank_lz;
         step(1);
      end
      load = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
